mem_arbiter: RTL and testbench

- Two-port arbiter that shares the single data-memory port (address/load/in/out/busy) between the CPU and a second bus master (DMA/debug loader).
- Sits between the cpu data interface, the DMA master and the memory block.
- Serialises accesses, honours memory busy stretching, and returns read data and a one-cycle ack to the winning requester.

---
 rtl/mem_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_mem_arbiter.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares the single data-memory port between the CPU and a second bus master
// (DMA / debug loader). Only one access is in flight at a time. The memory
// may stretch an access with mem_busy. Read data and a one-cycle ack go back
// to the master that won arbitration.
//
// Access timeline, with the request seen in cycle 0 and mem_busy low:
//   cycle 0 IDLE (grant), cycle 1 ISSUE, cycle 2 WAIT, cycle 3 ack.
// Each WAIT cycle with mem_busy high adds one cycle.
//
// Optional build macro:
//   ARB_TIMEOUT_EN - abort a WAIT that stays busy for TIMEOUT_CYCLES cycles.
//                    The ack is still given, with rdata forced to all-ones,
//                    and the sticky timeout flag is set. When the macro is
//                    undefined, WAIT lasts as long as mem_busy stays high and
//                    timeout is tied to 0.
//
// Ports:
//   clk, reset_n               clock, asynchronous active-low reset
//   cpu_req/we/addr/wdata      CPU request; fields held stable until cpu_ack
//   cpu_ack, cpu_rdata         one-cycle completion pulse, read data (held)
//   dma_req/we/addr/wdata      DMA request, same protocol as the CPU
//   dma_ack, dma_rdata         DMA completion pulse, read data (held)
//   mem_address, mem_wdata     to memory, held for the whole access
//   mem_load                   write strobe, high only in the ISSUE cycle
//   mem_rdata, mem_busy        from memory; busy high = access not finished
//   timeout                    sticky abort flag, cleared only by reset
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int unsigned ADDR_WIDTH     = 16,
    parameter int unsigned DATA_WIDTH     = 16,
    parameter int unsigned CPU_PRIORITY   = 1,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic                  clk,
    input  logic                  reset_n,

    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    output logic                  cpu_ack,
    output logic [DATA_WIDTH-1:0] cpu_rdata,

    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_ack,
    output logic [DATA_WIDTH-1:0] dma_rdata,

    output logic [ADDR_WIDTH-1:0] mem_address,
    output logic                  mem_load,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    input  logic                  mem_busy,

    output logic                  timeout
);

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT
    } state_t;

    // Last WAIT-cycle count before an abort (8-bit counter range).
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    state_t state;

    logic   owner_dma;   // winner of the access in flight
    logic   owner_we;    // access in flight is a write
    logic   last_dma;    // round-robin pointer: 1 = DMA was granted last

    // -----------------------------------------------------------------------
    // Arbitration (evaluated in IDLE only)
    // -----------------------------------------------------------------------
    logic                  cpu_elig;
    logic                  dma_elig;
    logic                  any_elig;
    logic                  pick_dma;
    logic                  sel_we;
    logic [ADDR_WIDTH-1:0] sel_addr;
    logic [DATA_WIDTH-1:0] sel_wdata;

    always_comb begin
        // A master in its ack cycle still shows req for the access that is
        // just finishing, so it must not be granted again in that cycle.
        cpu_elig = cpu_req & ~cpu_ack;
        dma_elig = dma_req & ~dma_ack;
        any_elig = cpu_elig | dma_elig;

        pick_dma = dma_elig;
        if (cpu_elig && dma_elig) begin
            if (CPU_PRIORITY != 0) begin
                pick_dma = 1'b0;
            end else begin
                pick_dma = ~last_dma;
            end
        end

        if (pick_dma) begin
            sel_we    = dma_we;
            sel_addr  = dma_addr;
            sel_wdata = dma_wdata;
        end else begin
            sel_we    = cpu_we;
            sel_addr  = cpu_addr;
            sel_wdata = cpu_wdata;
        end
    end

`ifdef ARB_TIMEOUT_EN
    logic [7:0] wait_cnt;
`else
    // Keeps the timeout parameter referenced when the feature is built out.
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = ^TO_LAST;
    assign timeout            = 1'b0;
`endif

    // -----------------------------------------------------------------------
    // Arbiter FSM; every output is a register written here.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            owner_dma   <= 1'b0;
            owner_we    <= 1'b0;
            last_dma    <= 1'b1;     // pretend DMA went last so the CPU wins the first tie
            cpu_ack     <= 1'b0;
            dma_ack     <= 1'b0;
            cpu_rdata   <= '0;
            dma_rdata   <= '0;
            mem_address <= '0;
            mem_wdata   <= '0;
            mem_load    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            wait_cnt    <= '0;
            timeout     <= 1'b0;
`endif
        end else begin
            // Acks are single-cycle pulses.
            cpu_ack <= 1'b0;
            dma_ack <= 1'b0;

            case (state)
                IDLE: begin
                    if (any_elig) begin
                        owner_dma   <= pick_dma;
                        last_dma    <= pick_dma;
                        owner_we    <= sel_we;
                        mem_address <= sel_addr;
                        mem_wdata   <= sel_wdata;
                        mem_load    <= sel_we;
                        state       <= ISSUE;
                    end
                end

                ISSUE: begin
                    mem_load <= 1'b0;
`ifdef ARB_TIMEOUT_EN
                    wait_cnt <= '0;
`endif
                    state    <= WAIT;
                end

                WAIT: begin
                    if (!mem_busy) begin
                        if (owner_dma) begin
                            dma_ack <= 1'b1;
                            if (!owner_we) begin
                                dma_rdata <= mem_rdata;
                            end
                        end else begin
                            cpu_ack <= 1'b1;
                            if (!owner_we) begin
                                cpu_rdata <= mem_rdata;
                            end
                        end
                        state <= IDLE;
                    end
`ifdef ARB_TIMEOUT_EN
                    else if (wait_cnt == TO_LAST) begin
                        // Abort: the requester is still released with an
                        // ack, and all-ones rdata marks the data as bad.
                        if (owner_dma) begin
                            dma_ack   <= 1'b1;
                            dma_rdata <= '1;
                        end else begin
                            cpu_ack   <= 1'b1;
                            cpu_rdata <= '1;
                        end
                        timeout <= 1'b1;
                        state   <= IDLE;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
`endif
                end

                default: begin
                    mem_load <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for mem_arbiter. Two instances run side by side: u_rr with
// round-robin arbitration and u_pri with CPU priority. Each master is driven
// by a small request queue that presents its head transaction and retires it
// on ack. The expected acks (cycle number and rdata) are queued when the
// stimulus is issued and are consumed by the negedge monitor. The memory
// model returns mem_address ^ 16'h1224 combinationally.
// ---------------------------------------------------------------------------
module tb_mem_arbiter;

    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // [dut][master]: dut 0 = round-robin, 1 = CPU priority; master 0 = CPU, 1 = DMA
    logic [1:0][1:0]       req   = '0;
    logic [1:0][1:0]       we    = '0;
    logic [1:0][1:0][15:0] addr  = '0;
    logic [1:0][1:0][15:0] wdata = '0;
    logic [1:0][1:0]       ack;
    logic [1:0][1:0][15:0] rdata;

    logic [1:0][15:0] maddr;
    logic [1:0][15:0] mwdata;
    logic [1:0][15:0] mrdata;
    logic [1:0]       mload;
    logic [1:0]       mbusy;
    logic [1:0]       tmo;

    assign mrdata[0] = maddr[0] ^ 16'h1224;
    assign mrdata[1] = maddr[1] ^ 16'h1224;

    mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .CPU_PRIORITY(0), .TIMEOUT_CYCLES(8)) u_rr (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(req[0][0]), .cpu_we(we[0][0]), .cpu_addr(addr[0][0]), .cpu_wdata(wdata[0][0]),
        .cpu_ack(ack[0][0]), .cpu_rdata(rdata[0][0]),
        .dma_req(req[0][1]), .dma_we(we[0][1]), .dma_addr(addr[0][1]), .dma_wdata(wdata[0][1]),
        .dma_ack(ack[0][1]), .dma_rdata(rdata[0][1]),
        .mem_address(maddr[0]), .mem_load(mload[0]), .mem_wdata(mwdata[0]),
        .mem_rdata(mrdata[0]), .mem_busy(mbusy[0]), .timeout(tmo[0]));

    mem_arbiter #(.ADDR_WIDTH(16), .DATA_WIDTH(16), .CPU_PRIORITY(1), .TIMEOUT_CYCLES(8)) u_pri (
        .clk(clk), .reset_n(reset_n),
        .cpu_req(req[1][0]), .cpu_we(we[1][0]), .cpu_addr(addr[1][0]), .cpu_wdata(wdata[1][0]),
        .cpu_ack(ack[1][0]), .cpu_rdata(rdata[1][0]),
        .dma_req(req[1][1]), .dma_we(we[1][1]), .dma_addr(addr[1][1]), .dma_wdata(wdata[1][1]),
        .dma_ack(ack[1][1]), .dma_rdata(rdata[1][1]),
        .mem_address(maddr[1]), .mem_load(mload[1]), .mem_wdata(mwdata[1]),
        .mem_rdata(mrdata[1]), .mem_busy(mbusy[1]), .timeout(tmo[1]));

    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [15:0] wd;
    } txn_t;

    typedef struct {
        logic [15:0] rd;
        int          c;
    } exp_t;

    txn_t mq[4][$];   // index dut*2 + master
    exp_t sb[4][$];

    int n_checks = 0;
    int n_pass   = 0;

    task automatic check(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s dut%0d: got %h expected %h (cycle %0d)", name, d, act, exp, cyc);
    endtask

    // Monitor (scoreboard) followed by the request drivers.
    always @(negedge clk) begin
        exp_t e;
        for (int d = 0; d < 2; d++) begin
            if (ack[d][0] || ack[d][1])
                check("no_double_ack", d, {31'b0, ack[d][0] & ack[d][1]}, 32'd0);
            for (int m = 0; m < 2; m++) begin
                if (ack[d][m]) begin
                    if (sb[d*2+m].size() == 0) begin
                        check($sformatf("%s_unexpected_ack", m ? "dma" : "cpu"), d, {31'b0, ack[d][m]}, 32'd0);
                    end else begin
                        e = sb[d*2+m].pop_front();
                        check($sformatf("%s_ack_cycle", m ? "dma" : "cpu"), d, cyc, e.c);
                        check($sformatf("%s_rdata", m ? "dma" : "cpu"), d, {16'b0, rdata[d][m]}, {16'b0, e.rd});
                    end
                end
            end
        end
        for (int k = 0; k < 4; k++) begin
            if (ack[k/2][k%2] && mq[k].size() > 0) void'(mq[k].pop_front());
            if (mq[k].size() > 0) begin
                req[k/2][k%2]   = 1'b1;
                we[k/2][k%2]    = mq[k][0].w;
                addr[k/2][k%2]  = mq[k][0].a;
                wdata[k/2][k%2] = mq[k][0].wd;
            end else begin
                req[k/2][k%2]   = 1'b0;
                we[k/2][k%2]    = 1'b0;
                addr[k/2][k%2]  = '0;
                wdata[k/2][k%2] = '0;
            end
        end
    end

    // Moves to 2 time units after the posedge that starts cycle c.
    task automatic at_cycle(input int c);
        if (cyc < c) begin
            while (cyc < c) begin
                @(posedge clk);
                #1;
            end
            #1;
        end
    endtask

    task automatic push(input int d, input int m, input logic w, input logic [15:0] a,
                        input logic [15:0] wd, input logic [15:0] rd, input int c);
        txn_t t;
        exp_t e;
        t.w = w; t.a = a; t.wd = wd;
        e.rd = rd; e.c = c;
        mq[d*2+m].push_back(t);
        sb[d*2+m].push_back(e);
    endtask

    task automatic push_both(input int m, input logic w, input logic [15:0] a,
                             input logic [15:0] wd, input logic [15:0] rd, input int c);
        push(0, m, w, a, wd, rd, c);
        push(1, m, w, a, wd, rd, c);
    endtask

    task automatic check_mem(input string name, input logic ld, input logic [15:0] a, input logic [15:0] wd);
        for (int d = 0; d < 2; d++) begin
            check({name, "_load"},  d, {31'b0, mload[d]}, {31'b0, ld});
            check({name, "_addr"},  d, {16'b0, maddr[d]}, {16'b0, a});
            check({name, "_wdata"}, d, {16'b0, mwdata[d]}, {16'b0, wd});
        end
    endtask

    initial begin
        reset_n = 1'b0;
        mbusy   = 2'b00;

        // Reset state
        at_cycle(2);
        check_mem("reset", 1'b0, 16'h0000, 16'h0000);
        for (int d = 0; d < 2; d++) begin
            check("reset_acks",    d, {30'b0, ack[d]}, 32'd0);
            check("reset_rdata",   d, {rdata[d][0], rdata[d][1]}, 32'd0);
            check("reset_timeout", d, {31'b0, tmo[d]}, 32'd0);
        end
        at_cycle(3);
        reset_n = 1'b1;

        // Tie straight after reset: pointer favours the CPU in both modes
        at_cycle(5);
        push_both(0, 1'b0, 16'h0001, 16'h0000, 16'h1225, 8);
        push_both(1, 1'b0, 16'h0002, 16'h0000, 16'h1226, 11);

        // CPU read, no busy
        at_cycle(14);
        push_both(0, 1'b0, 16'h0010, 16'h0000, 16'h1234, 17);
        at_cycle(15);
        check_mem("cpu_rd_issue", 1'b0, 16'h0010, 16'h0000);

        // DMA write, busy for 4 WAIT cycles; dma_rdata keeps its old value
        at_cycle(20);
        push_both(1, 1'b1, 16'h4000, 16'hBEEF, 16'h1226, 27);
        at_cycle(21);
        check_mem("dma_wr_issue", 1'b1, 16'h4000, 16'hBEEF);
        mbusy = 2'b11;
        at_cycle(22);
        check_mem("dma_wr_wait0", 1'b0, 16'h4000, 16'hBEEF);
        at_cycle(25);
        check_mem("dma_wr_wait3", 1'b0, 16'h4000, 16'hBEEF);
        at_cycle(26);
        mbusy = 2'b00;

        // Both held continuously: alternate CPU, DMA, CPU, DMA
        at_cycle(30);
        push_both(0, 1'b0, 16'h0100, 16'h0000, 16'h1324, 33);
        push_both(0, 1'b0, 16'h0102, 16'h0000, 16'h1326, 39);
        push_both(1, 1'b0, 16'h0200, 16'h0000, 16'h1024, 36);
        push_both(1, 1'b0, 16'h0202, 16'h0000, 16'h1026, 42);

        // CPU granted last, then a fresh tie: round-robin picks DMA, priority picks CPU
        at_cycle(45);
        push_both(0, 1'b0, 16'h0020, 16'h0000, 16'h1204, 48);
        at_cycle(50);
        push(0, 0, 1'b0, 16'h0030, 16'h0000, 16'h1214, 56);
        push(0, 1, 1'b0, 16'h0040, 16'h0000, 16'h1264, 53);
        push(1, 0, 1'b0, 16'h0030, 16'h0000, 16'h1214, 53);
        push(1, 1, 1'b0, 16'h0040, 16'h0000, 16'h1264, 56);

        // Reset during ISSUE of a DMA write; request stays held and is re-granted
        at_cycle(60);
        push_both(1, 1'b1, 16'h0500, 16'h00AA, 16'h0000, 65);
        at_cycle(61);
        check_mem("rst_wr_issue", 1'b1, 16'h0500, 16'h00AA);
        #1 reset_n = 1'b0;
        #1;
        check_mem("rst_async", 1'b0, 16'h0000, 16'h0000);
        for (int d = 0; d < 2; d++)
            check("rst_async_rdata", d, {rdata[d][0], rdata[d][1]}, 32'd0);
        at_cycle(62);
        reset_n = 1'b1;
        at_cycle(63);
        check_mem("rst_regrant_issue", 1'b1, 16'h0500, 16'h00AA);

        // Tie again after reset
        at_cycle(70);
        push_both(0, 1'b0, 16'h0060, 16'h0000, 16'h1244, 73);
        push_both(1, 1'b0, 16'h0070, 16'h0000, 16'h1254, 76);

        // Long busy: aborted by the timeout when enabled, otherwise waits it out
        at_cycle(80);
        mbusy = 2'b11;
`ifdef ARB_TIMEOUT_EN
        push_both(0, 1'b0, 16'h0080, 16'h0000, 16'hFFFF, 90);
        at_cycle(85);
        for (int d = 0; d < 2; d++) check("timeout_before", d, {31'b0, tmo[d]}, 32'd0);
        at_cycle(91);
        mbusy = 2'b00;
        for (int d = 0; d < 2; d++) check("timeout_set", d, {31'b0, tmo[d]}, 32'd1);
        at_cycle(98);
        push_both(0, 1'b0, 16'h0090, 16'h0000, 16'h12B4, 101);
        at_cycle(103);
        for (int d = 0; d < 2; d++) check("timeout_sticky", d, {31'b0, tmo[d]}, 32'd1);
`else
        push_both(0, 1'b0, 16'h0080, 16'h0000, 16'h12A4, 96);
        at_cycle(91);
        for (int d = 0; d < 2; d++) check("timeout_tied", d, {31'b0, tmo[d]}, 32'd0);
        at_cycle(95);
        mbusy = 2'b00;
        at_cycle(98);
        push_both(0, 1'b0, 16'h0090, 16'h0000, 16'h12B4, 101);
        at_cycle(103);
        for (int d = 0; d < 2; d++) check("timeout_tied_end", d, {31'b0, tmo[d]}, 32'd0);
`endif

        // Every expected ack must have arrived
        at_cycle(106);
        for (int k = 0; k < 4; k++)
            check($sformatf("pending_acks_q%0d", k), k / 2, sb[k].size(), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
